// File: rtl/cache_tag_ctrl_pkg.sv
// cache_tag_ctrl_pkg: address-field widths, line geometry and controller state encoding
package cache_tag_ctrl_pkg;
   localparam int OFFSET_W   = 4;
   localparam int INDEX_W    = 14;
   localparam int TAG_W      = 32 - INDEX_W - OFFSET_W;
   localparam int LINE_WORDS = 4;
   localparam int BEAT_W     = $clog2(LINE_WORDS);
   localparam int FILL_AW    = INDEX_W + OFFSET_W;
   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, DONE} state_t;
endpackage

// File: rtl/cache_tag_ctrl_if.sv
// cache_tag_ctrl_if: CPU request, memory and refill bus of the tag controller
//   master: CPU/memory/datapath environment; slave: cache_tag_ctrl
interface cache_tag_ctrl_if;
   import cache_tag_ctrl_pkg::*;
   logic               req_valid, req_ready, req_wr, hit, resp_valid;
   logic [31:0]        req_addr, req_wdata;
   logic               mem_rd_en, mem_rvalid, mem_wr_en, mem_wack;
   logic [31:0]        mem_addr, mem_rdata, mem_wdata;
   logic               fill_we;
   logic [FILL_AW-1:0] fill_addr;
   logic [31:0]        fill_data;
   modport master (
      output req_valid, req_addr, req_wr, req_wdata, mem_rdata, mem_rvalid, mem_wack,
      input  req_ready, hit, resp_valid, mem_rd_en, mem_addr, mem_wr_en, mem_wdata,
             fill_we, fill_addr, fill_data
   );
   modport slave (
      input  req_valid, req_addr, req_wr, req_wdata, mem_rdata, mem_rvalid, mem_wack,
      output req_ready, hit, resp_valid, mem_rd_en, mem_addr, mem_wr_en, mem_wdata,
             fill_we, fill_addr, fill_data
   );
endinterface

// File: rtl/cache_tag_ctrl_tag_ram.sv
// cache_tag_ram: direct-mapped tag + valid directory
//   clk, clr (async active-low, clears valid bits only)
//   ridx -> rtag/rvalid combinational read; we/widx/wtag write tag and set valid
module cache_tag_ram
   import cache_tag_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               clr,
   input  logic               we,
   input  logic [INDEX_W-1:0] ridx,
   input  logic [INDEX_W-1:0] widx,
   input  logic [TAG_W-1:0]   wtag,
   output logic [TAG_W-1:0]   rtag,
   output logic               rvalid
);
   logic [TAG_W-1:0]      tags [2**INDEX_W];
   logic [2**INDEX_W-1:0] valid;
   always_ff @(posedge clk or negedge clr)
      if (!clr) valid <= '0;
      else if (we) valid[widx] <= 1'b1;
   always_ff @(posedge clk)
      if (we) tags[widx] <= wtag;
   assign rtag   = tags[ridx];
   assign rvalid = valid[ridx];
endmodule

// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: direct-mapped tag lookup and 4-beat line-refill sequencer, write-through no-allocate
//   clk, clr (async active-low); bus: cache_tag_ctrl_if.slave (CPU request, memory, refill)
//   CACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs counted at lookup
module cache_tag_ctrl
   import cache_tag_ctrl_pkg::*;
(
   input logic              clk,
   input logic              clr,
   cache_tag_ctrl_if.slave  bus
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]      hit_cnt,
   output logic [31:0]      miss_cnt
`endif
);
   state_t              state;
   logic [31:0]         addr, wdata;
   logic                wr, hit_q, lookup_hit, tag_we, tag_valid;
   logic [BEAT_W-1:0]   beat;
   logic [INDEX_W-1:0]  idx;
   logic [TAG_W-1:0]    atag, rtag;
   assign idx        = addr[INDEX_W+OFFSET_W-1:OFFSET_W];
   assign atag       = addr[31:INDEX_W+OFFSET_W];
   assign lookup_hit = tag_valid && rtag == atag;
   // the cycle after the last beat (rd_en already dropped) commits the tag
   assign tag_we     = state == FILL && !bus.mem_rd_en;
   assign bus.hit    = state == LOOKUP ? lookup_hit : hit_q;
   cache_tag_ram u_tag_ram (
      .clk(clk), .clr(clr), .we(tag_we), .ridx(idx), .widx(idx), .wtag(atag),
      .rtag(rtag), .rvalid(tag_valid)
   );
   always_ff @(posedge clk or negedge clr)
      if (!clr) begin
         state         <= IDLE;
         addr          <= '0;
         wdata         <= '0;
         wr            <= 1'b0;
         beat          <= '0;
         hit_q         <= 1'b0;
         bus.req_ready <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.mem_rd_en <= 1'b0;
         bus.mem_wr_en <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.fill_we   <= 1'b0;
         bus.fill_addr <= '0;
         bus.fill_data <= '0;
      end else begin
         bus.resp_valid <= 1'b0;
         bus.fill_we    <= 1'b0;
         case (state)
            IDLE: if (bus.req_valid && bus.req_ready) begin
               addr          <= bus.req_addr;
               wr            <= bus.req_wr;
               wdata         <= bus.req_wdata;
               bus.req_ready <= 1'b0;
               state         <= LOOKUP;
            end
            LOOKUP: begin
               hit_q <= lookup_hit;
               if (wr) begin
                  bus.mem_wr_en <= 1'b1;
                  bus.mem_addr  <= addr & 32'hFFFF_FFFC;
                  bus.mem_wdata <= wdata;
                  state         <= WRITE;
               end else if (lookup_hit) state <= DONE;
               else begin
                  beat          <= '0;
                  bus.mem_rd_en <= 1'b1;
                  bus.mem_addr  <= {atag, idx, {BEAT_W{1'b0}}, 2'b00};
                  state         <= FILL;
               end
            end
            FILL: if (bus.mem_rd_en) begin
               if (bus.mem_rvalid) begin
                  bus.fill_we   <= 1'b1;
                  bus.fill_addr <= {idx, beat, 2'b00};
                  bus.fill_data <= bus.mem_rdata;
                  beat          <= beat + 1'b1;
                  bus.mem_rd_en <= beat != BEAT_W'(LINE_WORDS - 1);
                  bus.mem_addr  <= {atag, idx, beat + 1'b1, 2'b00};
               end
            end else state <= DONE;
            WRITE: if (bus.mem_wack) begin
               bus.mem_wr_en <= 1'b0;
               state         <= DONE;
            end
            DONE: begin
               bus.resp_valid <= 1'b1;
               bus.req_ready  <= 1'b1;
               hit_q          <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
`ifdef CACHE_STATS_EN
   always_ff @(posedge clk or negedge clr)
      if (!clr) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (state == LOOKUP) begin
         if (lookup_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
         if (!lookup_hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      end
`endif
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb_cache_tag_ctrl: directed self-checking bench for cache_tag_ctrl with a simple memory responder
module tb_cache_tag_ctrl;
   logic clk = 1'b0;
   logic clr = 1'b0;
   always #5 clk = ~clk;
   cache_tag_ctrl_if bus();
`ifdef CACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif
   cache_tag_ctrl dut (
      .clk(clk), .clr(clr), .bus(bus)
`ifdef CACHE_STATS_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );
   int passed = 0;
   int total  = 0;
   int rd_lat = 0, wr_lat = 0, rd_wait = 0, wr_wait = 0;
   bit spur = 1'b0;
   int resp_cnt = 0;
   logic [31:0] rd_q[$], wa_q[$], wd_q[$], fa_q[$], fd_q[$];
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction
   // memory model and monitor: samples DUT outputs and drives memory responses at negedge
   always @(negedge clk) begin
      if (bus.fill_we === 1'b1) begin
         fa_q.push_back({14'd0, bus.fill_addr});
         fd_q.push_back(bus.fill_data);
      end
      if (bus.resp_valid === 1'b1) resp_cnt++;
      bus.mem_rvalid = spur;
      bus.mem_wack   = spur;
      bus.mem_rdata  = 32'h0BAD_0BAD;
      if (bus.mem_rd_en === 1'b1 && !spur) begin
         if (rd_wait >= rd_lat) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mem_word(bus.mem_addr);
            rd_q.push_back(bus.mem_addr);
            rd_wait = 0;
         end else rd_wait++;
      end else rd_wait = 0;
      if (bus.mem_wr_en === 1'b1 && !spur) begin
         if (wr_wait >= wr_lat) begin
            bus.mem_wack = 1'b1;
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
            wr_wait = 0;
         end else wr_wait++;
      end else wr_wait = 0;
   end
   task automatic clear_logs();
      rd_q.delete(); wa_q.delete(); wd_q.delete(); fa_q.delete(); fd_q.delete();
      resp_cnt = 0;
   endtask
   task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                         output int cyc, output logic h);
      clear_logs();
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_addr = a; bus.req_wr = w; bus.req_wdata = d;
      @(negedge clk);
      bus.req_valid = 1'b0;
      h   = bus.hit;
      cyc = 1;
      while (bus.resp_valid !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
   endtask
   task automatic test_reset();
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wr = 1'b0; bus.req_wdata = '0;
      #12;
      total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.req_ready); else passed++;
      total++; if ({bus.resp_valid, bus.mem_rd_en, bus.mem_wr_en, bus.fill_we, bus.hit} !== 5'b0)
         $display("FAIL reset_flags got=%b exp=00000", {bus.resp_valid, bus.mem_rd_en, bus.mem_wr_en, bus.fill_we, bus.hit});
      else passed++;
      total++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); else passed++;
`ifdef CACHE_STATS_EN
      total++; if ({hit_cnt, miss_cnt} !== 64'h0) $display("FAIL reset_stats got=%h/%h exp=0/0", hit_cnt, miss_cnt); else passed++;
`endif
      @(negedge clk);
      clr = 1'b1;
   endtask
   task automatic test_cold_read();
      int cyc; logic h;
      access(32'h0000_0100, 1'b0, 32'h0, cyc, h);
      total++; if (h !== 1'b0) $display("FAIL cold_hit got=%b exp=0", h); else passed++;
      total++; if (cyc != 8) $display("FAIL cold_latency got=%0d exp=8", cyc); else passed++;
      total++; if (rd_q.size() != 4) $display("FAIL cold_rd_count got=%0d exp=4", rd_q.size()); else passed++;
      total++; if (fa_q.size() != 4) $display("FAIL cold_fill_count got=%0d exp=4", fa_q.size()); else passed++;
      for (int i = 0; i < 4 && i < rd_q.size() && i < fa_q.size(); i++) begin
         total++; if (rd_q[i] !== 32'h100 + 32'(4 * i)) $display("FAIL cold_rd_addr%0d got=%h exp=%h", i, rd_q[i], 32'h100 + 32'(4 * i)); else passed++;
         total++; if (fa_q[i] !== 32'h100 + 32'(4 * i)) $display("FAIL cold_fill_addr%0d got=%h exp=%h", i, fa_q[i], 32'h100 + 32'(4 * i)); else passed++;
         total++; if (fd_q[i] !== mem_word(32'h100 + 32'(4 * i))) $display("FAIL cold_fill_data%0d got=%h exp=%h", i, fd_q[i], mem_word(32'h100 + 32'(4 * i))); else passed++;
      end
      total++; if (resp_cnt != 1) $display("FAIL cold_resp_count got=%0d exp=1", resp_cnt); else passed++;
      total++; if (wa_q.size() != 0) $display("FAIL cold_wr_count got=%0d exp=0", wa_q.size()); else passed++;
   endtask
   task automatic test_read_hit();
      int cyc; logic h;
      access(32'h0000_0104, 1'b0, 32'h0, cyc, h);
      total++; if (h !== 1'b1) $display("FAIL hit_hit got=%b exp=1", h); else passed++;
      total++; if (cyc != 3) $display("FAIL hit_latency got=%0d exp=3", cyc); else passed++;
      total++; if (rd_q.size() != 0) $display("FAIL hit_rd_count got=%0d exp=0", rd_q.size()); else passed++;
      total++; if (fa_q.size() != 0) $display("FAIL hit_fill_count got=%0d exp=0", fa_q.size()); else passed++;
      total++; if (resp_cnt != 1) $display("FAIL hit_resp_count got=%0d exp=1", resp_cnt); else passed++;
   endtask
   task automatic test_replace();
      int cyc; logic h;
      rd_lat = 1;
      access(32'h0004_0100, 1'b0, 32'h0, cyc, h);
      total++; if (h !== 1'b0) $display("FAIL repl_hit got=%b exp=0", h); else passed++;
      total++; if (cyc != 12) $display("FAIL repl_latency got=%0d exp=12", cyc); else passed++;
      total++; if (rd_q.size() != 4 || rd_q[0] !== 32'h0004_0100 || rd_q[3] !== 32'h0004_010C)
         $display("FAIL repl_rd got=%0d beats first=%h exp=4 beats first=00040100", rd_q.size(), rd_q[0]);
      else passed++;
      total++; if (fa_q.size() != 4 || fa_q[0] !== 32'h100) $display("FAIL repl_fill got=%0d beats first=%h exp=4 beats first=100", fa_q.size(), fa_q[0]); else passed++;
      rd_lat = 0;
      access(32'h0000_0100, 1'b0, 32'h0, cyc, h);
      total++; if (h !== 1'b0) $display("FAIL reread_hit got=%b exp=0", h); else passed++;
      total++; if (rd_q.size() != 4) $display("FAIL reread_rd_count got=%0d exp=4", rd_q.size()); else passed++;
   endtask
   task automatic test_write();
      int cyc; logic h;
      wr_lat = 2;
      access(32'h0000_0108, 1'b1, 32'hDEAD_BEEF, cyc, h);
      total++; if (h !== 1'b1) $display("FAIL wr_hit got=%b exp=1", h); else passed++;
      total++; if (cyc != 6) $display("FAIL wr_latency got=%0d exp=6", cyc); else passed++;
      total++; if (wa_q.size() != 1 || wa_q[0] !== 32'h108 || wd_q[0] !== 32'hDEAD_BEEF)
         $display("FAIL wr_mem got=%0d writes %h:%h exp=1 write 00000108:deadbeef", wa_q.size(), wa_q[0], wd_q[0]);
      else passed++;
      total++; if (fa_q.size() + rd_q.size() != 0) $display("FAIL wr_no_fill got=%0d exp=0", fa_q.size() + rd_q.size()); else passed++;
      wr_lat = 0;
      access(32'h0000_2000, 1'b1, 32'h1234_5678, cyc, h);
      total++; if (h !== 1'b0) $display("FAIL wrmiss_hit got=%b exp=0", h); else passed++;
      total++; if (wa_q.size() != 1 || wa_q[0] !== 32'h2000 || wd_q[0] !== 32'h1234_5678)
         $display("FAIL wrmiss_mem got=%0d writes %h:%h exp=1 write 00002000:12345678", wa_q.size(), wa_q[0], wd_q[0]);
      else passed++;
      total++; if (fa_q.size() != 0) $display("FAIL wrmiss_fill got=%0d exp=0", fa_q.size()); else passed++;
      total++; if (cyc != 4) $display("FAIL wrmiss_latency got=%0d exp=4", cyc); else passed++;
   endtask
`ifdef CACHE_STATS_EN
   task automatic test_stats();
      total++; if (hit_cnt !== 32'd2) $display("FAIL stats_hit got=%0d exp=2", hit_cnt); else passed++;
      total++; if (miss_cnt !== 32'd4) $display("FAIL stats_miss got=%0d exp=4", miss_cnt); else passed++;
   endtask
`endif
   task automatic test_followups();
      int cyc; logic h;
      access(32'h0000_0104, 1'b0, 32'h0, cyc, h);
      total++; if (h !== 1'b1 || cyc != 3) $display("FAIL tags_kept got=hit%b/%0dcyc exp=hit1/3cyc", h, cyc); else passed++;
      access(32'h0000_2000, 1'b0, 32'h0, cyc, h);
      total++; if (h !== 1'b0 || fa_q.size() != 4) $display("FAIL no_allocate got=hit%b/%0dfills exp=hit0/4fills", h, fa_q.size()); else passed++;
   endtask
   task automatic test_busy();
      clear_logs();
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0104; bus.req_wr = 1'b0; spur = 1'b1;
      @(negedge clk);
      total++; if (bus.req_ready !== 1'b0) $display("FAIL busy_ready_lookup got=%b exp=0", bus.req_ready); else passed++;
      @(negedge clk);
      total++; if (bus.req_ready !== 1'b0) $display("FAIL busy_ready_done got=%b exp=0", bus.req_ready); else passed++;
      @(negedge clk);
      total++; if ({bus.resp_valid, bus.req_ready} !== 2'b11) $display("FAIL busy_resp got=%b exp=11", {bus.resp_valid, bus.req_ready}); else passed++;
      bus.req_valid = 1'b0; spur = 1'b0;
      repeat (5) @(negedge clk);
      total++; if (resp_cnt != 1) $display("FAIL busy_single_accept got=%0d exp=1", resp_cnt); else passed++;
      total++; if (fa_q.size() != 0) $display("FAIL spurious_rvalid got=%0d exp=0", fa_q.size()); else passed++;
   endtask
   task automatic test_clr_mid_fill();
      int cyc, n; logic h;
      clear_logs();
      rd_lat = 1;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0200; bus.req_wr = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      n = 0;
      while (fa_q.size() < 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++; if (fa_q.size() != 2) $display("FAIL clr_pre_beats got=%0d exp=2", fa_q.size()); else passed++;
      #2 clr = 1'b0;
      #1;
      total++; if (bus.req_ready !== 1'b1) $display("FAIL clr_ready got=%b exp=1", bus.req_ready); else passed++;
      total++; if ({bus.mem_rd_en, bus.fill_we, bus.hit, bus.resp_valid} !== 4'b0)
         $display("FAIL clr_flags got=%b exp=0000", {bus.mem_rd_en, bus.fill_we, bus.hit, bus.resp_valid});
      else passed++;
`ifdef CACHE_STATS_EN
      total++; if ({hit_cnt, miss_cnt} !== 64'h0) $display("FAIL clr_stats got=%h/%h exp=0/0", hit_cnt, miss_cnt); else passed++;
`endif
      @(negedge clk);
      clr = 1'b1;
      rd_lat = 0;
      total++; if (resp_cnt != 0) $display("FAIL clr_no_resp got=%0d exp=0", resp_cnt); else passed++;
      access(32'h0000_0200, 1'b0, 32'h0, cyc, h);
      total++; if (h !== 1'b0) $display("FAIL clr_reread_hit got=%b exp=0", h); else passed++;
      total++; if (rd_q.size() != 4 || fa_q.size() != 4) $display("FAIL clr_refill got=%0d/%0d exp=4/4", rd_q.size(), fa_q.size()); else passed++;
      total++; if (cyc != 8) $display("FAIL clr_reread_latency got=%0d exp=8", cyc); else passed++;
      access(32'h0000_0100, 1'b0, 32'h0, cyc, h);
      total++; if (h !== 1'b0) $display("FAIL clr_old_line_hit got=%b exp=0", h); else passed++;
   endtask
   initial begin
      test_reset();
      test_cold_read();
      test_read_hit();
      test_replace();
      test_write();
`ifdef CACHE_STATS_EN
      test_stats();
`endif
      test_followups();
      test_busy();
      test_clr_mid_fill();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
